binary_search_ctrl: RTL and testbench
=====================================

BINARY_SEARCH_CTRL -- requirements
Module: binary_search_ctrl

Interface
REQ-001 SHALL have parameter BIT, default 4, operand width in bits (legal BIT >= 2).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block's only clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a search; sampled only in IDLE.
REQ-005 SHALL have port guess  output  BIT  registered probe value, drives num1 of an external comparator_nbit whose num2 is the hidden target.
REQ-006 SHALL have port gt  input  1  comparator feedback, guess > target.
REQ-007 SHALL have port eq  input  1  comparator feedback, guess == target.
REQ-008 SHALL have port ls  input  1  comparator feedback, guess < target.
REQ-009 SHALL have port busy  output  1  high while in SEARCH.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a search ends, good or bad.
REQ-011 SHALL have port result  output  BIT  found value; valid when done=1 and err=0; held until next accepted start.
REQ-012 SHALL have port err  output  1  search failed; held until next accepted start.
REQ-013 SHALL have port iters  output  BIT  count of feedback samples taken in the current or last search.

Function
REQ-014 SHALL implement FSM states IDLE, SEARCH and FIN, with internal BIT-bit registers low and high.
REQ-015 SHALL, in IDLE with start=1, load low=0 and high=2^BIT-1, clear err and iters, and set guess=2^(BIT-1)-1, then go to SEARCH.
REQ-016 SHALL ignore start in SEARCH and FIN.
REQ-017 SHALL sample gt/eq/ls on every rising edge in SEARCH, with the comparator treated as combinational on guess, and increment iters on each sample.
REQ-018 SHALL treat feedback as invalid unless exactly one of gt, eq, ls is 1; invalid feedback sets err=1 and goes to FIN.
REQ-019 SHALL, on eq=1, set result=guess and go to FIN.
REQ-020 SHALL, on gt=1: if guess==low, set err=1 and go to FIN; else set high=guess-1 and guess=low+((guess-1-low)>>1).
REQ-021 SHALL, on ls=1: if guess==high, set err=1 and go to FIN; else set low=guess+1 and guess=(guess+1)+((high-guess-1)>>1).
REQ-022 SHALL compute every midpoint as low+((high-low)>>1) in BIT-bit unsigned arithmetic, with no wrap-around.
REQ-023 SHALL, if the (BIT+1)-th sample is not eq and causes no other exit, set err=1 and go to FIN (watchdog).
REQ-024 SHALL assert done=1 for exactly the one cycle spent in FIN, then return to IDLE.
REQ-025 SHALL assert busy=1 only in SEARCH.
REQ-026 SHALL hold guess, result, err and iters stable in IDLE and FIN.
REQ-027 SHALL allow a start in the cycle right after FIN (IDLE), giving back-to-back searches.

Reset
REQ-028 SHALL, on rst_n=0 at any time including mid-search, go to IDLE immediately, with guess=0, result=0, err=0, iters=0, busy=0, done=0, low=0 and high=0.
REQ-029 SHALL, after rst_n deasserts, accept start no earlier than the first rising clk edge.

Verification
REQ-030 SHALL verify, with BIT=4, target 9 and start pulsed: guess sequence 7, 11, 9; done in the cycle after eq; result=9, err=0, iters=3.
REQ-031 SHALL verify, with target 15: guess sequence 7, 11, 13, 14, 15; result=15, iters=5, err=0.
REQ-032 SHALL verify, with target 0: guess sequence 7, 3, 1, 0; result=0, iters=4, err=0.
REQ-033 SHALL verify that forcing gt=1 and ls=1 together on the first sample gives err=1, done pulse, iters=1, and result unchanged.
REQ-034 SHALL verify that driving rst_n=0 during the second SEARCH cycle gives all outputs 0 at once and no done pulse; a later start with target 13 completes with result=13.
REQ-035 SHALL verify that start held high throughout gives back-to-back searches, with start ignored while busy=1 and exactly one done pulse per search.

Source files
------------

// File: rtl/binary_search_ctrl.sv
// Binary search controller: steers an external comparator toward a hidden target
// by narrowing [low, high] on each gt/eq/ls feedback sample.
module binary_search_ctrl #(
   parameter int unsigned BIT = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   output logic [BIT-1:0] guess,
   input  logic           gt,
   input  logic           eq,
   input  logic           ls,
   output logic           busy,
   output logic           done,
   output logic [BIT-1:0] result,
   output logic           err,
   output logic [BIT-1:0] iters
);

   localparam logic [BIT-1:0] MAX_VAL    = '1;
   localparam logic [BIT-1:0] INIT_GUESS = MAX_VAL >> 1;
   // iters value seen while taking the (BIT+1)-th sample
   localparam logic [BIT-1:0] LAST_ITER  = BIT'(BIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      FIN    = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [BIT-1:0] low_q, low_d;
   logic [BIT-1:0] high_q, high_d;
   logic [BIT-1:0] guess_q, guess_d;
   logic [BIT-1:0] result_q, result_d;
   logic [BIT-1:0] iters_q, iters_d;
   logic           err_q, err_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic           fb_valid_c;
   logic [BIT-1:0] dn_high_c;
   logic [BIT-1:0] up_low_c;

   // Lower midpoint of a non-empty range; lo <= hi so the subtraction cannot wrap
   function automatic logic [BIT-1:0] midpoint(input logic [BIT-1:0] lo,
                                               input logic [BIT-1:0] hi);
      return lo + ((hi - lo) >> 1);
   endfunction

   assign fb_valid_c = ({gt, eq, ls} == 3'b100) ||
                       ({gt, eq, ls} == 3'b010) ||
                       ({gt, eq, ls} == 3'b001);
   assign dn_high_c  = guess_q - BIT'(1);
   assign up_low_c   = guess_q + BIT'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         low_q    <= '0;
         high_q   <= '0;
         guess_q  <= '0;
         result_q <= '0;
         iters_q  <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         low_q    <= low_d;
         high_q   <= high_d;
         guess_q  <= guess_d;
         result_q <= result_d;
         iters_q  <= iters_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      low_d    = low_q;
      high_d   = high_q;
      guess_d  = guess_q;
      result_d = result_q;
      iters_d  = iters_q;
      err_d    = err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               low_d   = '0;
               high_d  = MAX_VAL;
               guess_d = INIT_GUESS;
               iters_d = '0;
               err_d   = 1'b0;
               state_d = SEARCH;
            end
         end
         SEARCH: begin
            iters_d = iters_q + BIT'(1);
            // Exits are ordered: bad feedback, hit, exhausted range, watchdog, then narrow
            if (!fb_valid_c) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else if (eq) begin
               result_d = guess_q;
               state_d  = FIN;
            end else if (gt && (guess_q == low_q)) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else if (ls && (guess_q == high_q)) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else if (iters_q == LAST_ITER) begin
               err_d   = 1'b1;
               state_d = FIN;
            end else if (gt) begin
               high_d  = dn_high_c;
               guess_d = midpoint(low_q, dn_high_c);
            end else begin
               low_d   = up_low_c;
               guess_d = midpoint(up_low_c, high_q);
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SEARCH);
      done_d = (state_d == FIN);
   end

   assign guess  = guess_q;
   assign result = result_q;
   assign iters  = iters_q;
   assign err    = err_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_binary_search_ctrl.sv
// Scoreboard bench for binary_search_ctrl: a behavioural binary search predicts
// probe sequences and final outcomes; a negedge monitor checks what the DUT shows.
module tb_binary_search_ctrl;

   localparam int unsigned BIT = 4;
   localparam int          MAXV = (1 << BIT) - 1;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [BIT-1:0] guess;
   logic           gt, eq, ls;
   logic           busy, done, err;
   logic [BIT-1:0] result, iters;

   int             target;
   bit             fb_force;

   typedef struct {
      int result;
      int err;
      int iters;
   } exp_t;

   exp_t exp_q[$];
   int   exp_g_q[$];
   int   prev_result;
   int   checks;
   int   errors;
   int   done_cnt;

   binary_search_ctrl #(.BIT(BIT)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .guess  (guess),
      .gt     (gt),
      .eq     (eq),
      .ls     (ls),
      .busy   (busy),
      .done   (done),
      .result (result),
      .err    (err),
      .iters  (iters)
   );

   // Combinational comparator on guess; fb_force drives an illegal gt+ls pattern
   assign gt = fb_force ? 1'b1 : (int'(guess) > target);
   assign ls = fb_force ? 1'b1 : (int'(guess) < target);
   assign eq = fb_force ? 1'b0 : (int'(guess) == target);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s: scoreboard had no matching expectation", name);
   endtask

   // Reference: textbook lower-midpoint binary search over [0, MAXV]
   task automatic model(input int t);
      int   lo, hi, mid, n;
      exp_t e;
      lo = 0;
      hi = MAXV;
      n  = 0;
      forever begin
         mid = lo + (hi - lo) / 2;
         exp_g_q.push_back(mid);
         n++;
         if (mid == t) break;
         if (mid > t) hi = mid - 1;
         else         lo = mid + 1;
      end
      e.result = t;
      e.err    = 0;
      e.iters  = n;
      exp_q.push_back(e);
      prev_result = t;
   endtask

   task automatic wait_busy();
      int n;
      n = 0;
      while (busy !== 1'b1 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk("start_accept", busy, 1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_seen", done, 1);
      @(posedge clk); #1;
   endtask

   task automatic do_search(input int t, input bit hold);
      target = t;
      model(t);
      start = 1'b1;
      wait_busy();
      if (!hold) start = 1'b0;
      wait_done();
   endtask

   task automatic bad_feedback_search();
      exp_t e;
      target   = 5;
      fb_force = 1'b1;
      exp_g_q.push_back(MAXV / 2);
      e.result = prev_result;
      e.err    = 1;
      e.iters  = 1;
      exp_q.push_back(e);
      start = 1'b1;
      wait_busy();
      start = 1'b0;
      wait_done();
      fb_force = 1'b0;
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {guess, result, iters, err, busy, done}, 0);
   endtask

   // Monitor: consumes one probe per SEARCH cycle and one outcome per done pulse
   bit             prev_nb;
   logic [31:0]    prev_vec;
   always @(negedge clk) begin
      exp_t e;
      int   g;
      if (!rst_n) begin
         prev_nb = 1'b0;
      end else begin
         if (busy) begin
            if (exp_g_q.size() == 0) flag("guess_unexpected");
            else begin
               g = exp_g_q.pop_front();
               chk("guess", guess, g);
            end
         end
         if (done) begin
            done_cnt++;
            chk("done_busy_excl", busy, 0);
            chk("probes_consumed", exp_g_q.size(), 0);
            if (exp_q.size() == 0) flag("done_unexpected");
            else begin
               e = exp_q.pop_front();
               chk("result", result, e.result);
               chk("err", err, e.err);
               chk("iters", iters, e.iters);
            end
         end
         if (!busy && prev_nb)
            chk("idle_hold_stable", {guess, result, iters, err}, prev_vec);
         prev_nb  = !busy;
         prev_vec = {guess, result, iters, err};
      end
   end

   initial begin
      int d0;
      checks      = 0;
      errors      = 0;
      done_cnt    = 0;
      prev_result = 0;
      fb_force    = 1'b0;
      target      = 0;
      start       = 1'b0;
      rst_n       = 1'b1;
      #2 rst_n = 1'b0;
      #1 chk_all_zero("reset_state");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      do_search(9, 1'b0);
      chk("t9_result", result, 9);
      chk("t9_iters", iters, 3);
      do_search(15, 1'b0);
      chk("t15_iters", iters, 5);
      do_search(0, 1'b0);
      chk("t0_iters", iters, 4);

      bad_feedback_search();
      chk("bad_fb_err", err, 1);
      chk("bad_fb_result", result, 0);

      // Abort mid-search with an asynchronous reset
      target = 13;
      model(13);
      start = 1'b1;
      wait_busy();
      start = 1'b0;
      @(posedge clk); #1;
      d0 = done_cnt;
      rst_n = 1'b0;
      #1 chk_all_zero("reset_mid_search");
      exp_q.delete();
      exp_g_q.delete();
      prev_result = 0;
      repeat (3) @(posedge clk);
      #1 chk("no_done_on_reset", done_cnt, d0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_search(13, 1'b0);
      chk("t13_after_reset", result, 13);

      for (int i = 0; i < 20; i++)
         do_search(int'($urandom_range(0, MAXV)), 1'b0);

      // start held high: back-to-back searches, one done each
      d0 = done_cnt;
      for (int i = 0; i < 5; i++)
         do_search(int'($urandom_range(0, MAXV)), 1'b1);
      start = 1'b0;
      chk("held_start_dones", done_cnt - d0, 5);

      repeat (4) @(posedge clk);
      #1;
      chk("busy_final", busy, 0);
      chk("exp_q_empty", exp_q.size(), 0);
      chk("exp_g_q_empty", exp_g_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
